// File: rtl/tty_tx_if.sv
// Console teleprinter IOT bus: CPU-side controls and device status/serial lines.
// Bit order of instruction/ac is PDP-8 style [0:11] (bit 0 is the MSB).
interface tty_tx_if;
    logic [4:0]  state;
    logic [0:11] instruction;
    logic [0:11] ac;
    logic        UF;
    logic        tx;
    logic        skip;
    logic        irq;
    logic        flag;
    logic        tx_busy;

    modport master (
        output state, instruction, ac, UF,
        input  tx, skip, irq, flag, tx_busy
    );

    modport slave (
        input  state, instruction, ac, UF,
        output tx, skip, irq, flag, tx_busy
    );
endinterface

// File: rtl/tty_tx.sv
// Teleprinter output (IOT 604x, KIE 6035): async serialiser, printer flag, skip/irq.
// Optional TTY_MARK_PARITY_EN forces the 8th data bit (ac[4]) to mark.
module tty_tx #(
    parameter int         CLKS_PER_BIT = 104,
    parameter int         STOP_BITS    = 1,
    parameter logic [4:0] F3           = 5'd3
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     clear,
    tty_tx_if.slave  bus
);

    localparam int BW = $clog2(STOP_BITS * CLKS_PER_BIT) + 1;
    localparam logic [BW-1:0] BIT_END  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] STOP_END = BW'(STOP_BITS * CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} fsm_t;

    fsm_t          fsm;
    logic [BW-1:0] baud;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic [7:0]    hold;
    logic          hold_full;
    logic          ie;
    logic          flag_q;
    logic          tx_q;

    logic [7:0] char_in;
    logic       iot;
    logic       kie;
    logic       tfl, tsf, tcf, tpc, tsk, tls;
    logic       load;
    logic       stop_end;
    logic       load_direct;
    logic       unused_ac;

    assign iot = (bus.state == F3) && !bus.UF
               && (bus.instruction[0:8] == 9'o604);
    assign kie = (bus.state == F3) && !bus.UF
               && (bus.instruction == 12'o6035);

    assign tfl = iot && (bus.instruction[9:11] == 3'o0);
    assign tsf = iot && (bus.instruction[9:11] == 3'o1);
    assign tcf = iot && (bus.instruction[9:11] == 3'o2);
    assign tpc = iot && (bus.instruction[9:11] == 3'o4);
    assign tsk = iot && (bus.instruction[9:11] == 3'o5);
    assign tls = iot && (bus.instruction[9:11] == 3'o6);

`ifdef TTY_MARK_PARITY_EN
    assign char_in   = {1'b1, bus.ac[5:11]};
    assign unused_ac = ^bus.ac[0:4];
`else
    assign char_in   = bus.ac[4:11];
    assign unused_ac = ^bus.ac[0:3];
`endif

    assign load     = tpc || tls;
    assign stop_end = (fsm == STOP) && (baud == STOP_END);
    // A load skips the holding register only when nothing is queued ahead of it.
    assign load_direct = load && !hold_full && ((fsm == IDLE) || stop_end);

    assign bus.skip    = (tsf && flag_q) || (tsk && flag_q && ie);
    assign bus.irq     = flag_q && ie;
    assign bus.flag    = flag_q;
    assign bus.tx      = tx_q;
    assign bus.tx_busy = (fsm != IDLE) || hold_full;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            fsm       <= IDLE;
            tx_q      <= 1'b1;
            flag_q    <= 1'b0;
            ie        <= 1'b1;
            hold_full <= 1'b0;
            hold      <= 8'd0;
            shift     <= 8'd0;
            baud      <= '0;
            bit_cnt   <= 3'd0;
        end else begin
            if (kie) ie <= bus.ac[11];
            if (stop_end || tfl) flag_q <= 1'b1;
            if (tcf || tls) flag_q <= 1'b0;

            unique case (fsm)
                IDLE: begin
                    tx_q <= 1'b1;
                    baud <= '0;
                    if (load_direct) begin
                        shift <= char_in;
                        fsm   <= START;
                        tx_q  <= 1'b0;
                    end else if (hold_full) begin
                        shift     <= hold;
                        hold_full <= 1'b0;
                        fsm       <= START;
                        tx_q      <= 1'b0;
                    end
                end
                START: begin
                    if (baud == BIT_END) begin
                        baud    <= '0;
                        bit_cnt <= 3'd0;
                        fsm     <= DATA;
                        tx_q    <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud == BIT_END) begin
                        baud <= '0;
                        if (bit_cnt == 3'd7) begin
                            fsm  <= STOP;
                            tx_q <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx_q    <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (stop_end) begin
                        baud <= '0;
                        if (hold_full) begin
                            shift     <= hold;
                            hold_full <= 1'b0;
                            fsm       <= START;
                            tx_q      <= 1'b0;
                        end else if (load_direct) begin
                            shift <= char_in;
                            fsm   <= START;
                            tx_q  <= 1'b0;
                        end else begin
                            fsm  <= IDLE;
                            tx_q <= 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: fsm <= IDLE;
            endcase

            // Placed after the FSM so a queued load re-arms hold_full.
            if (load && !load_direct) begin
                hold      <= char_in;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tty_tx.sv
// Directed bench for tty_tx with CLKS_PER_BIT=4, STOP_BITS=1.
// Define TTY_MARK_PARITY_EN for both DUT and bench to check mark parity.
module tb_tty_tx;

    localparam logic [4:0] F3 = 5'd3;

    logic clk = 1'b0;
    logic reset;
    logic clear;
    int   checks = 0;
    int   errors = 0;

    tty_tx_if bus ();

    tty_tx #(
        .CLKS_PER_BIT(4),
        .STOP_BITS(1),
        .F3(F3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] tchar(input logic [11:0] a);
        logic [7:0] c;
        c = a[7:0];
`ifdef TTY_MARK_PARITY_EN
        c[7] = 1'b1;
`endif
        return c;
    endfunction

    function automatic logic exp_tx(input logic [7:0] d, input int i);
        int b;
        b = i / 4;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    task automatic idle_bus();
        bus.state       = 5'd0;
        bus.instruction = 12'o0000;
        bus.ac          = 12'o0000;
        bus.UF          = 1'b0;
    endtask

    task automatic iot(input logic [11:0] ins, input logic [11:0] a,
                       input logic uf);
        @(negedge clk);
        bus.state       = F3;
        bus.instruction = ins;
        bus.ac          = a;
        bus.UF          = uf;
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    task automatic skip_chk(input string tag, input logic [11:0] ins,
                            input logic uf, input logic exp);
        @(negedge clk);
        bus.state       = F3;
        bus.instruction = ins;
        bus.UF          = uf;
        #1;
        chk(tag, bus.skip, exp);
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    // Called 1 time unit after the load edge; ends 1 unit after edge 40.
    task automatic frame_chk(input string tag, input logic [7:0] d,
                             input logic flag_before);
        for (int i = 0; i < 40; i++) begin
            chk(tag, bus.tx, exp_tx(d, i));
            if (i == 39) chk({tag, "_flag39"}, bus.flag, flag_before);
            @(posedge clk);
            #1;
        end
        chk({tag, "_flag40"}, bus.flag, 1'b1);
    endtask

    initial begin
        idle_bus();
        reset = 1'b1;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_tx", bus.tx, 1'b1);
        chk("rst_flag", bus.flag, 1'b0);
        chk("rst_irq", bus.irq, 1'b0);
        chk("rst_busy", bus.tx_busy, 1'b0);
        chk("rst_skip", bus.skip, 1'b0);

        skip_chk("tsf_flag0", 12'o6041, 1'b0, 1'b0);

        // Single frame of 'A'
        iot(12'o6046, 12'o0101, 1'b0);
        chk("a_busy", bus.tx_busy, 1'b1);
        frame_chk("frame_a", tchar(12'o0101), 1'b0);
        chk("a_irq", bus.irq, 1'b1);
        chk("a_idle_tx", bus.tx, 1'b1);
        chk("a_idle_busy", bus.tx_busy, 1'b0);

        skip_chk("tsf_flag1", 12'o6041, 1'b0, 1'b1);
        skip_chk("tsf_uf", 12'o6041, 1'b1, 1'b0);
        iot(12'o6042, 12'o0000, 1'b1);
        chk("tcf_uf_flag", bus.flag, 1'b1);
        @(negedge clk);
        bus.instruction = 12'o6041;
        #1;
        chk("tsf_not_f3", bus.skip, 1'b0);
        idle_bus();

        iot(12'o6042, 12'o0000, 1'b0);
        chk("tcf_flag", bus.flag, 1'b0);
        iot(12'o6040, 12'o0000, 1'b0);
        chk("tfl_flag", bus.flag, 1'b1);

        // Back-to-back: TLS 'A' then TPC 'B' two cycles later
        iot(12'o6046, 12'o0101, 1'b0);
        @(posedge clk);
        iot(12'o6044, 12'o0102, 1'b0);
        chk("b2b_flag_tpc", bus.flag, 1'b0);
        for (int i = 2; i < 80; i++) begin
            chk("b2b_tx", bus.tx,
                exp_tx((i < 40) ? tchar(12'o0101) : tchar(12'o0102), i % 40));
            chk("b2b_busy", bus.tx_busy, 1'b1);
            @(posedge clk);
            #1;
        end
        chk("b2b_end_busy", bus.tx_busy, 1'b0);
        chk("b2b_end_flag", bus.flag, 1'b1);
        chk("b2b_end_tx", bus.tx, 1'b1);

        // Interrupt enable
        iot(12'o6035, 12'o0000, 1'b0);
        chk("kie0_irq", bus.irq, 1'b0);
        chk("kie0_flag", bus.flag, 1'b1);
        skip_chk("tsk_ie0", 12'o6045, 1'b0, 1'b0);
        iot(12'o6035, 12'o0001, 1'b0);
        chk("kie1_irq", bus.irq, 1'b1);
        skip_chk("tsk_ie1", 12'o6045, 1'b0, 1'b1);

        // TCF on the final STOP cycle: clear wins
        iot(12'o6046, 12'o0101, 1'b0);
        repeat (39) @(posedge clk);
        iot(12'o6042, 12'o0000, 1'b0);
        chk("eos_tcf_flag", bus.flag, 1'b0);
        chk("eos_tcf_tx", bus.tx, 1'b1);
        chk("eos_tcf_busy", bus.tx_busy, 1'b0);

        // TPC on the final STOP cycle chains straight into the next frame
        iot(12'o6046, 12'o0102, 1'b0);
        repeat (39) @(posedge clk);
        iot(12'o6044, 12'o0101, 1'b0);
        chk("eos_ld_flag", bus.flag, 1'b1);
        chk("eos_ld_busy", bus.tx_busy, 1'b1);
        frame_chk("eos_ld_frame", tchar(12'o0101), 1'b1);

        // Clear mid-DATA aborts the frame and restores ie
        iot(12'o6035, 12'o0000, 1'b0);
        iot(12'o6046, 12'o0101, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_clr_tx", bus.tx, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clr_tx", bus.tx, 1'b1);
        chk("clr_flag", bus.flag, 1'b0);
        chk("clr_busy", bus.tx_busy, 1'b0);
        for (int i = 0; i < 45; i++) begin
            chk("clr_quiet_tx", bus.tx, 1'b1);
            @(posedge clk);
            #1;
        end
        iot(12'o6040, 12'o0000, 1'b0);
        chk("clr_ie_irq", bus.irq, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
